// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg
// Shared types and constants for the shared-adder round-robin controller.
//   state_t   : controller FSM states (IDLE, CALC, RESP)
//   req_id_t  : requester identifier (two requesters -> 1 bit)
//   RESET_PTR : requester favoured by the arbiter after reset
package adder_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic req_id_t;

    localparam req_id_t RESET_PTR = 1'b0;

endpackage : adder_arbiter_pkg

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Two-way round-robin arbiter with its own priority pointer.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset (pointer -> RESET_PTR)
//   enable_i   in   grants are only issued while enabled
//   req_i      in   [1:0] request vector
//   update_i   in   a grant was accepted this cycle; pointer moves past it
//   grant_o    out  [1:0] one-hot grant (0 when disabled or no request)
//   grant_id_o out  index of the granted requester
module rr_arbiter2
    import adder_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] grant_o,
    output req_id_t    grant_id_o
);

    req_id_t ptr_q;
    req_id_t ptr_d;

    always_comb begin
        grant_o    = 2'b00;
        grant_id_o = ptr_q;
        if (enable_i) begin
            case (req_i)
                2'b01: begin
                    grant_o    = 2'b01;
                    grant_id_o = 1'b0;
                end
                2'b10: begin
                    grant_o    = 2'b10;
                    grant_id_o = 1'b1;
                end
                2'b11: begin
                    // Contention: the pointer names the favoured requester.
                    grant_o    = ptr_q ? 2'b10 : 2'b01;
                    grant_id_o = ptr_q;
                end
                default: begin
                    grant_o    = 2'b00;
                    grant_id_o = ptr_q;
                end
            endcase
        end
    end

    // After any accepted grant, favour the requester that was not served,
    // even if it was the only one asking.
    always_comb begin
        ptr_d = ptr_q;
        if (update_i) begin
            ptr_d = ~grant_id_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= RESET_PTR;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : rr_arbiter2

// File: rtl/adder_arbiter.sv
// adder_arbiter
// Shares one registered WIDTH-bit adder between two requesters. A request is
// granted round-robin in IDLE, its operands are latched, the sum is
// registered in CALC and held in RESP until the consumer accepts it.
// Optional feature: define ADDER_SAT_EN to saturate res_data to all ones on
// carry-out (res_carry still reports the overflow).
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   req_valid [1:0]  requester i presents operands
//   req_ready [1:0]  one-hot grant, only in IDLE
//   a0, b0 / a1, b1  operand pairs of requester 0 / 1
//   res_valid        result held (RESP)
//   res_ready        consumer accepts result
//   res_data         sum (wrapped, or saturated with ADDER_SAT_EN)
//   res_carry        carry-out of the full WIDTH+1-bit sum
//   res_id           requester that owns the result
//   busy             high whenever the controller is not IDLE
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_id,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    req_id_t          op_id_q;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_carry_q, res_carry_d;
    req_id_t          res_id_q;

    logic [1:0]       grant;
    req_id_t          grant_id;
    logic             req_hs;
    logic [WIDTH:0]   sum_full;

    // Arbiter is only enabled in IDLE, so req_ready has no path from
    // res_ready and is zero while an operation is in flight.
    rr_arbiter2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .enable_i   (state_q == IDLE),
        .req_i      (req_valid),
        .update_i   (req_hs),
        .grant_o    (grant),
        .grant_id_o (grant_id)
    );

    assign req_ready = grant;
    assign req_hs    = |(req_valid & grant);

    assign sum_full = {1'b0, op_a_q} + {1'b0, op_b_q};

    always_comb begin
        res_carry_d = sum_full[WIDTH];
`ifdef ADDER_SAT_EN
        res_data_d  = sum_full[WIDTH] ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
`else
        res_data_d  = sum_full[WIDTH-1:0];
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_hs) state_d = CALC;
            CALC:    state_d = RESP;
            RESP:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req_hs) begin
                op_a_q  <= grant_id ? a1 : a0;
                op_b_q  <= grant_id ? b1 : b0;
                op_id_q <= grant_id;
            end
            // Result registers only load in CALC, so they stay frozen
            // through any amount of back-pressure in RESP.
            if (state_q == CALC) begin
                res_data_q  <= res_data_d;
                res_carry_q <= res_carry_d;
                res_id_q    <= op_id_q;
            end
        end
    end

    assign res_valid = (state_q == RESP);
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != IDLE);

endmodule : adder_arbiter

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] a0, b0, a1, b1;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_carry;
    logic       res_id;
    logic       busy;

    always #5 clk = ~clk;

    adder_arbiter #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_carry (res_carry),
        .res_id    (res_id),
        .busy      (busy)
    );

`ifdef ADDER_SAT_EN
    localparam logic [7:0] E_F0_20 = 8'hFF;
    localparam logic [7:0] E_80_90 = 8'hFF;
    localparam logic [7:0] E_FF_01 = 8'hFF;
    localparam logic [7:0] E_FF_FF = 8'hFF;
`else
    localparam logic [7:0] E_F0_20 = 8'h10;
    localparam logic [7:0] E_80_90 = 8'h10;
    localparam logic [7:0] E_FF_01 = 8'h00;
    localparam logic [7:0] E_FF_FF = 8'hFE;
`endif

    typedef struct packed {
        logic       id;
        logic       carry;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t mk(input logic id, input logic carry, input logic [7:0] data);
        exp_t e;
        e.id    = id;
        e.carry = carry;
        e.data  = data;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted result is popped from the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: actual id=%0d data=%h required=none", res_id, res_data);
            end else begin
                e = sb_q.pop_front();
                $display("result id=%0d data=%h carry=%0d (exp id=%0d data=%h carry=%0d)",
                         res_id, res_data, res_carry, e.id, e.data, e.carry);
                check("res_id", {31'd0, res_id}, {31'd0, e.id});
                check("res_data", {24'd0, res_data}, {24'd0, e.data});
                check("res_carry", {31'd0, res_carry}, {31'd0, e.carry});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, {30'd0, req_ready}, 32'd0);
        check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        check({tag, "_res_data"}, {24'd0, res_data}, 32'd0);
        check({tag, "_res_carry"}, {31'd0, res_carry}, 32'd0);
        check({tag, "_res_id"}, {31'd0, res_id}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Present requests, wait (bounded) for a grant, check it, record the
    // expected result, and return just after the handshake edge (CALC).
    task automatic issue(input logic [1:0] v, input logic exp_id, input exp_t e);
        int t;
        t = 0;
        req_valid = v;
        #1;
        while (req_ready == 2'b00 && t < 20) begin
            step();
            #1;
            t++;
        end
        check("grant", {30'd0, req_ready}, exp_id ? 32'd2 : 32'd1);
        $display("grant req_valid=%b req_ready=%b", v, req_ready);
        sb_q.push_back(e);
        step();
    endtask

    task automatic wait_res();
        int t;
        t = 0;
        while (!res_valid && t < 20) begin
            step();
            t++;
        end
        check("res_valid_wait", {31'd0, res_valid}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_zero("por");
        rst = 1'b0;
        step();

        // Reset while a result is held in RESP
        a0 = 8'h10; b0 = 8'h01; a1 = 8'h20; b1 = 8'h02;
        issue(2'b11, 1'b0, mk(1'b0, 1'b0, 8'h11));
        req_valid = 2'b00;
        wait_res();
        step();
        rst = 1'b1;
        #1;
        sb_q.delete();
        check_zero("midreset");
        step();
        rst = 1'b0;
        step();
        res_ready = 1'b1;
        // Pointer must be back at requester 0
        issue(2'b11, 1'b0, mk(1'b0, 1'b0, 8'h11));
        req_valid = 2'b00;
        wait_res();
        step();

        // Single request and latency
        a0 = 8'h12; b0 = 8'h34;
        issue(2'b01, 1'b0, mk(1'b0, 1'b0, 8'h46));
        req_valid = 2'b00;
        check("calc_res_valid", {31'd0, res_valid}, 32'd0);
        check("calc_busy", {31'd0, busy}, 32'd1);
        step();
        check("latency_res_valid", {31'd0, res_valid}, 32'd1);
        step();
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Overflow via requester 1 alone
        a1 = 8'hF0; b1 = 8'h20;
        issue(2'b10, 1'b1, mk(1'b1, 1'b1, E_F0_20));
        req_valid = 2'b00;
        wait_res();
        step();

        // Five back-to-back operations with both requesting
        a0 = 8'h01; b0 = 8'h02; a1 = 8'h80; b1 = 8'h90;
        issue(2'b11, 1'b0, mk(1'b0, 1'b0, 8'h03));
        a0 = 8'h7F; b0 = 8'h01;
        issue(2'b11, 1'b1, mk(1'b1, 1'b1, E_80_90));
        a1 = 8'hFF; b1 = 8'h01;
        issue(2'b11, 1'b0, mk(1'b0, 1'b0, 8'h80));
        a0 = 8'hFF; b0 = 8'hFF;
        issue(2'b11, 1'b1, mk(1'b1, 1'b1, E_FF_01));
        issue(2'b11, 1'b0, mk(1'b0, 1'b1, E_FF_FF));
        req_valid = 2'b00;
        wait_res();
        step();

        // Back-pressure for 4 cycles with both still requesting
        res_ready = 1'b0;
        a0 = 8'h55; b0 = 8'h0A; a1 = 8'h33; b1 = 8'h44;
        issue(2'b11, 1'b1, mk(1'b1, 1'b0, 8'h77));
        wait_res();
        for (int i = 0; i < 4; i++) begin
            check("bp_res_valid", {31'd0, res_valid}, 32'd1);
            check("bp_res_data", {24'd0, res_data}, 32'h77);
            check("bp_res_id", {31'd0, res_id}, 32'd1);
            check("bp_req_ready", {30'd0, req_ready}, 32'd0);
            step();
        end
        res_ready = 1'b1;
        #1;
        check("bp_release_req_ready", {30'd0, req_ready}, 32'd0);
        step();
        issue(2'b11, 1'b0, mk(1'b0, 1'b0, 8'h5F));
        req_valid = 2'b00;
        wait_res();
        step();

        // Requester 1 raises then drops its request while 0 is in service
        a0 = 8'h01; b0 = 8'h01; a1 = 8'hAA; b1 = 8'h11;
        issue(2'b01, 1'b0, mk(1'b0, 1'b0, 8'h02));
        req_valid = 2'b11;
        step();
        req_valid = 2'b00;
        step();
        check("drop_req_ready", {30'd0, req_ready}, 32'd0);
        repeat (3) step();
        check("drop_busy", {31'd0, busy}, 32'd0);
        check("drop_res_valid", {31'd0, res_valid}, 32'd0);
        check("sb_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_adder_arbiter
